arranque_rampa_param: RTL

Parametrised soft-start ramp controller for the motor drive; successor to the fixed 3-step starter. Steps a speed level from 0 (off) up to N_LEVELS, holding each step for a programmable dwell time. Dwell depends on mode: Rapido selects fast, Lento selects slow. Ramps back down to off when the run request drops. Output is one level per step, one-hot, and feeds the drive's speed selector.

---
 rtl/arranque_pkg.sv | 15 +
 rtl/arranque_temporizador.sv | 35 +++
 rtl/arranque_rampa_param.sv | 138 +++++++++++++
 3 files changed

// File: rtl/arranque_pkg.sv
// Shared types and default dwell constants for the soft-start ramp controller.
// Optional stop input is enabled by defining PARO_EN.
package arranque_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRampUp,
        StRun,
        StRampDown
    } arranque_state_e;

    localparam int unsigned DWELL_FAST_DEF = 25;
    localparam int unsigned DWELL_SLOW_DEF = 100;

endpackage

// File: rtl/arranque_temporizador.sv
// Dwell counter: raises step once the count reaches dwell-1, then restarts from zero.
module arranque_temporizador #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               step_o
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;

    // ">=" rather than "==" so a shorter dwell picked mid-step fires at once.
    assign step_o = en_i && (cnt_q >= (dwell_i - DWELL_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || step_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/arranque_rampa_param.sv
// Parametrised soft-start ramp: steps a one-hot speed level up/down with mode-dependent dwell.
// Defining PARO_EN adds the 'paro' stop input, which forces the ramp back to off.
module arranque_rampa_param
    import arranque_pkg::*;
#(
    parameter int unsigned N_LEVELS   = 3,
    parameter int unsigned DWELL_W    = 8,
    parameter int unsigned DWELL_FAST = DWELL_FAST_DEF,
    parameter int unsigned DWELL_SLOW = DWELL_SLOW_DEF,
    localparam int unsigned LvlW      = $clog2(N_LEVELS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Rapido,
    input  logic                Lento,
`ifdef PARO_EN
    input  logic                paro,
`endif
    output logic [N_LEVELS-1:0] out_lvl,
    output logic [LvlW-1:0]     level_idx,
    output logic                ramping,
    output logic                at_top
);

    localparam logic [DWELL_W-1:0] DwellFast = DWELL_W'(DWELL_FAST);
    localparam logic [DWELL_W-1:0] DwellSlow = DWELL_W'(DWELL_SLOW);
    localparam logic [LvlW-1:0]    LvlTop    = LvlW'(N_LEVELS);

    arranque_state_e    state_q, state_d;
    logic [LvlW-1:0]    level_q, level_d;
    logic               req;
    logic               tmr_clr, tmr_en, tmr_step;
    logic [DWELL_W-1:0] dwell_sel;

    assign req = Rapido | Lento;

    arranque_temporizador #(
        .DWELL_W (DWELL_W)
    ) u_temporizador (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .dwell_i (dwell_sel),
        .step_o  (tmr_step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        dwell_sel = DwellSlow;
        unique case (state_q)
            StIdle: begin
                tmr_clr = 1'b1;
                if (req) begin
                    level_d = LvlW'(1);
                    state_d = StRampUp;
                end
            end
            StRampUp: begin
                if (!req) begin
                    tmr_clr = 1'b1;
                    state_d = StRampDown;
                end else begin
                    tmr_en    = 1'b1;
                    dwell_sel = Rapido ? DwellFast : DwellSlow;
                    if (tmr_step) begin
                        if (level_q < LvlTop) begin
                            level_d = level_q + LvlW'(1);
                        end
                        if (level_q >= LvlTop - LvlW'(1)) begin
                            state_d = StRun;
                        end
                    end
                end
            end
            StRun: begin
                tmr_clr = 1'b1;
                if (!req) begin
                    state_d = StRampDown;
                end
            end
            StRampDown: begin
                if (req) begin
                    tmr_clr = 1'b1;
                    state_d = StRampUp;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_step) begin
                        if (level_q != '0) begin
                            level_d = level_q - LvlW'(1);
                        end
                        if (level_q <= LvlW'(1)) begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
                level_d = '0;
                tmr_clr = 1'b1;
            end
        endcase
`ifdef PARO_EN
        // Stop overrides any request; restart needs paro low and a request.
        if (paro) begin
            state_d = StIdle;
            level_d = '0;
            tmr_clr = 1'b1;
            tmr_en  = 1'b0;
        end
`endif
    end

    always_comb begin
        out_lvl = '0;
        for (int k = 0; k < N_LEVELS; k++) begin
            out_lvl[k] = (level_q == LvlW'(k + 1));
        end
        level_idx = level_q;
        ramping   = (state_q == StRampUp) || (state_q == StRampDown);
        at_top    = (state_q == StRun);
    end

endmodule
